// File: rtl/alu_ops_pkg.sv
// Shared operand-bus definitions: the entry-state enum and the operand word field layout
// used by both the operand builder and the shift stage.
package alu_ops_pkg;

  localparam int OPERANDS_W  = 10;
  localparam int TORIGHT_BIT = 9;
  localparam int BIN_MSB     = 8;
  localparam int BIN_LSB     = 3;
  localparam int SHAMT_W     = 3;
  localparam int BIN_W       = BIN_MSB - BIN_LSB + 1;

  // Encodings double as the phase value shown to the user.
  typedef enum logic [1:0] {
    S_DIR   = 2'd0,
    S_BIN   = 2'd1,
    S_SHAMT = 2'd2,
    S_SEND  = 2'd3
  } state_e;

endpackage

// File: rtl/button_conditioner.sv
// Turns an asynchronous push button into a single-cycle press pulse: 2-flop synchronizer,
// optional counter debounce (compile with DEBOUNCE_EN), then a registered rising-edge detector.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_prev_q, level_prev_d;
  logic pulse_q, pulse_d;
  logic level;

  // Empty marker block that only shows up in the hierarchy when the parameter is out of range.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_debounce_cycles_out_of_range
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // cnt_q counts consecutive samples that disagree with the accepted level; any agreeing
  // sample restarts it, and the level flips on the DEBOUNCE_CYCLES-th disagreeing sample.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    level_prev_d = level;
    pulse_d      = level & ~level_prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_prev_q <= level_prev_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/operand_builder.sv
// Assembles the {toRight, binary, shamt} operand word one field per Enter press and offers it
// on a valid/ready handshake. Optional button debounce is enabled with the DEBOUNCE_EN macro.
module operand_builder
  import alu_ops_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BIN_W-1:0]      sw,
  input  logic                  btn_enter,
  input  logic                  btn_clear,
  input  logic                  operands_ready,
  output logic [OPERANDS_W-1:0] operands,
  output logic                  operands_valid,
  output logic [1:0]            phase
);

  logic enter_pulse;
  logic clear_pulse;

  state_e                  state_q, state_d;
  logic [1:0]              phase_q, phase_d;
  logic [OPERANDS_W-1:0]   operands_q, operands_d;
  logic                    valid_q, valid_d;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_enter),
    .pulse   (enter_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_clear),
    .pulse   (clear_pulse)
  );

  // Clear wins over Enter and over a same-cycle handshake.
  always_comb begin
    state_d    = state_q;
    operands_d = operands_q;
    valid_d    = valid_q;
    if (clear_pulse) begin
      state_d    = S_DIR;
      operands_d = '0;
      valid_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_DIR: if (enter_pulse) begin
          operands_d[TORIGHT_BIT] = sw[0];
          state_d                 = S_BIN;
        end
        S_BIN: if (enter_pulse) begin
          operands_d[BIN_MSB:BIN_LSB] = sw;
          state_d                     = S_SHAMT;
        end
        S_SHAMT: if (enter_pulse) begin
          operands_d[SHAMT_W-1:0] = sw[SHAMT_W-1:0];
          state_d                 = S_SEND;
          valid_d                 = 1'b1;
        end
        S_SEND: if (valid_q && operands_ready) begin
          valid_d = 1'b0;
          state_d = S_DIR;
        end
        default: state_d = S_DIR;
      endcase
    end
    phase_d = state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_DIR;
      phase_q    <= 2'd0;
      operands_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      operands_q <= operands_d;
      valid_q    <= valid_d;
    end
  end

  assign operands       = operands_q;
  assign operands_valid = valid_q;
  assign phase          = phase_q;

endmodule

// File: tb/tb_operand_builder.sv
// Scoreboard bench for operand_builder: randomized and directed button/switch stimulus against
// a field-level model; completed words are queued and checked when the DUT hands them over.
module tb_operand_builder;

`ifdef DEBOUNCE_EN
  localparam int DEB = 8;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT    = 3 + DEB;
  localparam int HOLD   = LAT + 4;
  localparam int SETTLE = LAT + 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] sw = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic       operands_ready = 1'b0;
  logic [9:0] operands;
  logic       operands_valid;
  logic [1:0] phase;

  operand_builder #(.DEBOUNCE_CYCLES(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sw             (sw),
    .btn_enter      (btn_enter),
    .btn_clear      (btn_clear),
    .operands_ready (operands_ready),
    .operands       (operands),
    .operands_valid (operands_valid),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: how many fields have been entered, their values, and the pending word.
  bit         m_dir;
  logic [5:0] m_bin;
  logic [2:0] m_sh;
  int         m_fields;
  bit         m_valid;
  logic [9:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [9:0] m_word();
    return {m_dir, m_bin, m_sh};
  endfunction

  task automatic model_reset();
    m_dir = 1'b0; m_bin = '0; m_sh = '0; m_fields = 0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_press(bit en, bit cl, logic [5:0] s);
    if (cl) begin
      if (m_valid) void'(exp_q.pop_back());
      m_dir = 1'b0; m_bin = '0; m_sh = '0; m_fields = 0; m_valid = 1'b0;
    end else if (en && !m_valid) begin
      case (m_fields)
        0: m_dir = s[0];
        1: m_bin = s;
        default: m_sh = s[2:0];
      endcase
      m_fields++;
      if (m_fields == 3) begin
        m_valid = 1'b1;
        exp_q.push_back(m_word());
      end
    end
    if (m_valid && operands_ready) begin
      m_valid = 1'b0;
      m_fields = 0;
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(string name);
    check({name, "_phase"}, 32'(phase), 32'(m_fields));
    check({name, "_valid"}, 32'(operands_valid), 32'(m_valid));
    check({name, "_operands"}, 32'(operands), 32'(m_word()));
  endtask

  task automatic press(bit en, bit cl, logic [5:0] s, string name);
    model_press(en, cl, s);
    sw = s; btn_enter = en; btn_clear = cl;
    tick(HOLD);
    btn_enter = 1'b0; btn_clear = 1'b0;
    tick(SETTLE);
    check_state(name);
  endtask

  task automatic set_ready(bit v);
    operands_ready = v;
    tick(2);
    if (v && m_valid) begin
      m_valid = 1'b0;
      m_fields = 0;
    end
    check_state("ready_change");
  endtask

  // Monitor: every handshake must deliver the oldest word still owed.
  always @(negedge clk) begin
    if (reset_n && operands_valid && operands_ready) begin
      if (exp_q.size() == 0) check("unexpected_transfer", 32'(operands), 32'hFFFF_FFFF);
      else check("transfer", 32'(operands), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d checks made", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [9:0] held;
    model_reset();
    tick(3);
    check_state("reset");
    reset_n = 1'b1;
    tick(2);

    // Directed word with ready high, plus Enter-to-valid latency on the last field.
    operands_ready = 1'b1;
    press(1, 0, 6'b000001, "dir");
    press(1, 0, 6'b101101, "bin");
    model_press(1, 0, 6'b000011);
    sw = 6'b000011; btn_enter = 1'b1;
    cnt = 0;
    while (!operands_valid && cnt < LAT + 10) begin
      @(posedge clk); #1; cnt++;
    end
    check("enter_latency", 32'(cnt), 32'(LAT + 1));
    check("word_1101101011", 32'(operands), 32'h36B);
    tick(4);
    btn_enter = 1'b0;
    tick(SETTLE);
    check_state("after_send");

    // Back-pressure: word held while ready low, extra Enter presses ignored.
    operands_ready = 1'b0;
    press(1, 0, 6'b000000, "bp_dir");
    press(1, 0, 6'b010110, "bp_bin");
    press(1, 0, 6'b000101, "bp_sh");
    held = operands;
    press(1, 0, 6'b111111, "bp_extra1");
    press(1, 0, 6'b101010, "bp_extra2");
    check("bp_held", 32'(operands), 32'(held));
    operands_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 32'(operands_valid), 32'd0);
    m_valid = 1'b0; m_fields = 0;
    tick(2);
    check_state("bp_done");

    // Clear in S_SHAMT, then Clear together with Enter in S_BIN.
    press(1, 0, 6'b000001, "cl_dir");
    press(1, 0, 6'b110011, "cl_bin");
    press(0, 1, 6'b000111, "clear_shamt");
    press(1, 0, 6'b000001, "ce_dir");
    press(1, 1, 6'b111111, "clear_enter");

`ifdef DEBOUNCE_EN
    // Bouncing Enter: only the final stable rise yields a pulse.
    model_press(1, 0, 6'b000001);
    sw = 6'b000001;
    btn_enter = 1'b1; tick(3);
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1;
    cnt = 0;
    while (phase != 2'd1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    check("bounce_latency", 32'(cnt), 32'(LAT + 1));
    tick(20 - cnt);
    btn_enter = 1'b0;
    tick(SETTLE);
    check_state("bounce_single");
    press(0, 1, 6'b000000, "bounce_clear");
`endif

    // Asynchronous reset in S_BIN.
    press(1, 0, 6'b000001, "rst_dir");
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state("async_reset_bin");
    tick(2);
    reset_n = 1'b1;
    tick(SETTLE);
    check_state("after_reset_bin");

    // Asynchronous reset while the button is still working through the conditioner.
    btn_enter = 1'b1;
    tick(LAT - 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("async_reset_mid");
    btn_enter = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(SETTLE);
    check_state("after_reset_mid");

    // Randomized entry, clears and ready toggling.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) press(0, 1, 6'($urandom), "rnd_clear");
      else if (r == 1) set_ready(~operands_ready);
      else press(1, 0, 6'($urandom), "rnd_enter");
    end
    set_ready(1'b1);
    tick(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
